// File: rtl/axi4s_img_pkg.sv
// Shared defaults, derived constants and beat record for the image-verify AXI4-Stream path.
package axi4s_img_pkg;
  localparam int PIX_W_DEF  = 24;
  localparam int PPC_DEF    = 4;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int FCNT_W_DEF = 16;
  localparam int DW         = PIX_W_DEF * PPC_DEF;
  localparam int BPL        = IMG_W_DEF / PPC_DEF;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic          eol;
    logic          eof;
    logic          sof;
  } beat_t;

  typedef enum logic [1:0] {SK_EMPTY, SK_FULL1, SK_FULL2} skid_state_t;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi4s_skid_slice.sv
// Two-entry register slice (main + skid): full throughput, ready fully registered.
module axi4s_skid_slice
  import axi4s_img_pkg::*;
#(
  parameter int W = $bits(beat_t)
) (
  input  logic         clock,
  input  logic         i_rstn,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  skid_state_t  state, nxt;
  logic [W-1:0] skid;
  logic         accept, pop, load_main, load_skid, skid_to_main;

  assign accept  = s_valid & s_ready;
  assign m_valid = (state != SK_EMPTY);
  assign pop     = m_valid & m_ready;

  always_comb begin
    nxt          = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      SK_EMPTY: if (accept) begin
        nxt       = SK_FULL1;
        load_main = 1'b1;
      end
      SK_FULL1: begin
        if (accept && !pop) begin
          nxt       = SK_FULL2;
          load_skid = 1'b1;
        end else if (accept && pop) begin
          load_main = 1'b1;
        end else if (pop) begin
          nxt = SK_EMPTY;
        end
      end
      SK_FULL2: if (pop) begin
        nxt          = SK_FULL1;
        skid_to_main = 1'b1;
      end
      default: nxt = SK_EMPTY;
    endcase
  end

  // Ready looks one state ahead so it drops in the same edge the skid fills.
  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= SK_EMPTY;
      s_ready <= 1'b0;
    end else begin
      state   <= nxt;
      s_ready <= (nxt != SK_FULL2);
    end
  end

  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      m_data <= '0;
      skid   <= '0;
    end else begin
      if (load_main)         m_data <= s_data;
      else if (skid_to_main) m_data <= skid;
      if (load_skid)         skid   <= s_data;
    end
  end
endmodule

// File: rtl/axi4s_frame_tagger.sv
// AXI4-Stream stage that tags each beat with eol/eof/sof from internal col/row counters.
module axi4s_frame_tagger
  import axi4s_img_pkg::*;
#(
  parameter  int PIX_W  = PIX_W_DEF,
  parameter  int PPC    = PPC_DEF,
  parameter  int IMG_W  = IMG_W_DEF,
  parameter  int IMG_H  = IMG_H_DEF,
  parameter  int FCNT_W = FCNT_W_DEF,
  localparam int TDW    = PIX_W * PPC,
  localparam int TBPL   = IMG_W / PPC,
  localparam int CW     = cnt_w(TBPL),
  localparam int RW     = cnt_w(IMG_H)
) (
  input  logic              clock,
  input  logic              i_rstn,
  input  logic [TDW-1:0]    s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [TDW-1:0]    m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              eol,
  output logic              eof,
  output logic              sof,
  output logic [CW-1:0]     o_col,
  output logic [RW-1:0]     o_row,
  output logic [FCNT_W-1:0] o_frame_cnt
);
  localparam logic [CW-1:0] COL_LAST = CW'(TBPL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic           accept, eol_c, eof_c, sof_c;
  logic [TDW+2:0] s_beat, m_beat;

  assign accept = s_axis_tvalid & s_axis_tready;
  assign eol_c  = (o_col == COL_LAST);
  assign eof_c  = eol_c & (o_row == ROW_LAST);
  assign sof_c  = (o_col == '0) & (o_row == '0);
  assign s_beat = {s_axis_tdata, eol_c, eof_c, sof_c};

  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      o_col       <= '0;
      o_row       <= '0;
      o_frame_cnt <= '0;
    end else if (accept) begin
      if (eol_c) begin
        o_col <= '0;
        if (eof_c) begin
          o_row       <= '0;
          o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
        end else begin
          o_row <= o_row + RW'(1);
        end
      end else begin
        o_col <= o_col + CW'(1);
      end
    end
  end

  // Tags ride in the slice alongside the pixels, so stalls cannot skew them.
  axi4s_skid_slice #(.W(TDW + 3)) u_slice (
    .clock   (clock),
    .i_rstn  (i_rstn),
    .s_data  (s_beat),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_beat),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, eol, eof, sof} = m_beat;
endmodule

// File: tb/tb_axi4s_frame_tagger.sv
// Directed table plus corner sequences and a scoreboarded random stream for axi4s_frame_tagger.
module tb_axi4s_frame_tagger;
  localparam int DWT = 32;

  logic            clock, i_rstn;
  logic [DWT-1:0]  s_axis_tdata, m_axis_tdata;
  logic            s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic            eol, eof, sof;
  logic            o_col, o_row;
  logic [1:0]      o_frame_cnt;

  int n_vec = 0;
  int n_bad = 0;

  axi4s_frame_tagger #(
    .PIX_W(8), .PPC(4), .IMG_W(8), .IMG_H(2), .FCNT_W(2)
  ) dut (
    .clock        (clock),
    .i_rstn       (i_rstn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .eol          (eol),
    .eof          (eof),
    .sof          (sof),
    .o_col        (o_col),
    .o_row        (o_row),
    .o_frame_cnt  (o_frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic           sv;
    logic [DWT-1:0] d;
    logic           mr;
    logic           sr;
    logic           mv;
    logic [DWT-1:0] md;
    logic [2:0]     tags;  // {eol, eof, sof}
    logic [1:0]     fc;
    logic           col;
    logic           row;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sv, input logic [DWT-1:0] d, input logic mr,
                              input logic sr, input logic mv, input logic [DWT-1:0] md,
                              input logic [2:0] tags, input logic [1:0] fc,
                              input logic col, input logic row);
    vec_t v;
    v.sv = sv; v.d = d; v.mr = mr; v.sr = sr; v.mv = mv; v.md = md;
    v.tags = tags; v.fc = fc; v.col = col; v.row = row;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [DWT-1:0] d, input logic mr);
    s_axis_tvalid = sv;
    s_axis_tdata  = d;
    m_axis_tready = mr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_rstn        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    @(posedge clock);
    #3;
    i_rstn = 1'b1;
    step(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [DWT-1:0] hold_d;
    logic           hold_v, acc, pop, mcol, mrow;
    logic [1:0]     mfc;
    logic [DWT+2:0] exp_q[$];
    logic [DWT+2:0] e;
    int             sent, cycles;

    // reset + continuous stream, backpressure, push/pop in FULL1
    tbl.push_back(mk(1, 32'hD0, 1, 1, 0, 32'h0,  3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 32'hD0, 1, 1, 1, 32'hD0, 3'b001, 0, 1, 0));
    tbl.push_back(mk(1, 32'hD1, 1, 1, 1, 32'hD1, 3'b100, 0, 0, 1));
    tbl.push_back(mk(1, 32'hD2, 1, 1, 1, 32'hD2, 3'b000, 0, 1, 1));
    tbl.push_back(mk(1, 32'hD3, 1, 1, 1, 32'hD3, 3'b110, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,  1, 1, 0, 32'h0,  3'b000, 1, 0, 0));
    tbl.push_back(mk(1, 32'hB0, 0, 1, 1, 32'hB0, 3'b001, 1, 1, 0));
    tbl.push_back(mk(1, 32'hB1, 0, 0, 1, 32'hB0, 3'b001, 1, 0, 1));
    tbl.push_back(mk(1, 32'hB2, 0, 0, 1, 32'hB0, 3'b001, 1, 0, 1));
    tbl.push_back(mk(1, 32'hB2, 1, 1, 1, 32'hB1, 3'b100, 1, 0, 1));
    tbl.push_back(mk(1, 32'hB2, 1, 1, 1, 32'hB2, 3'b000, 1, 1, 1));
    tbl.push_back(mk(1, 32'hB3, 1, 1, 1, 32'hB3, 3'b110, 2, 0, 0));
    tbl.push_back(mk(0, 32'h0,  1, 1, 0, 32'h0,  3'b000, 2, 0, 0));
    tbl.push_back(mk(1, 32'hAAAAAAAA, 0, 1, 1, 32'hAAAAAAAA, 3'b001, 2, 1, 0));
    tbl.push_back(mk(1, 32'hBBBBBBBB, 1, 1, 1, 32'hBBBBBBBB, 3'b100, 2, 0, 1));
    tbl.push_back(mk(0, 32'h0,        0, 1, 1, 32'hBBBBBBBB, 3'b100, 2, 0, 1));
    tbl.push_back(mk(1, 32'hCCCCCCCC, 1, 1, 1, 32'hCCCCCCCC, 3'b000, 2, 1, 1));
    tbl.push_back(mk(1, 32'hDDDDDDDD, 1, 1, 1, 32'hDDDDDDDD, 3'b110, 3, 0, 0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,        3'b000, 3, 0, 0));

    i_rstn        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst s_ready", 64'(s_axis_tready), 0);
    chk("rst m_valid", 64'(m_axis_tvalid), 0);
    chk("rst tags",    64'({eol, eof, sof}), 0);
    chk("rst fcnt",    64'(o_frame_cnt), 0);
    #2 i_rstn = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].sv, tbl[i].d, tbl[i].mr);
      chk($sformatf("v%0d s_ready", i), 64'(s_axis_tready), 64'(tbl[i].sr));
      chk($sformatf("v%0d m_valid", i), 64'(m_axis_tvalid), 64'(tbl[i].mv));
      chk($sformatf("v%0d col/row", i), 64'({o_col, o_row}), 64'({tbl[i].col, tbl[i].row}));
      chk($sformatf("v%0d fcnt", i),    64'(o_frame_cnt), 64'(tbl[i].fc));
      if (tbl[i].mv) begin
        chk($sformatf("v%0d tdata", i), 64'(m_axis_tdata), 64'(tbl[i].md));
        chk($sformatf("v%0d tags", i),  64'({eol, eof, sof}), 64'(tbl[i].tags));
      end
    end

    // reset mid-frame after beat 3
    step(1, 32'hE0, 1);
    step(1, 32'hE1, 1);
    step(1, 32'hE2, 1);
    chk("pre-rst m_valid", 64'(m_axis_tvalid), 1);
    #2 i_rstn = 1'b0;
    #1;
    chk("mid-rst s_ready", 64'(s_axis_tready), 0);
    chk("mid-rst m_valid", 64'(m_axis_tvalid), 0);
    chk("mid-rst tdata",   64'(m_axis_tdata), 0);
    chk("mid-rst tags",    64'({eol, eof, sof}), 0);
    chk("mid-rst cnt",     64'({o_col, o_row, o_frame_cnt}), 0);
    s_axis_tvalid = 1'b0;
    #2 i_rstn = 1'b1;
    step(1, 32'hF0, 1);
    chk("post-rst s_ready", 64'(s_axis_tready), 1);
    chk("post-rst m_valid", 64'(m_axis_tvalid), 0);
    step(1, 32'hF0, 1);
    chk("post-rst tdata", 64'(m_axis_tdata), 32'hF0);
    chk("post-rst tags",  64'({eol, eof, sof}), 3'b001);
    chk("post-rst fcnt",  64'(o_frame_cnt), 0);

    // frame counter wrap: 1,2,3,0,1
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 4; b++) step(1, DWT'(f * 16 + b), 1);
      chk($sformatf("wrap f%0d eof", f),  64'({m_axis_tvalid, eof}), 2'b11);
      chk($sformatf("wrap f%0d fcnt", f), 64'(o_frame_cnt), 64'((f + 1) % 4));
    end
    step(0, '0, 1);

    // random valid/ready against an independent col/row model
    do_reset();
    mcol = 0; mrow = 0; mfc = 0;
    sent = 0; cycles = 0;
    hold_v = 0; hold_d = '0;
    while ((sent < 1000 || exp_q.size() > 0) && cycles < 20000) begin
      if (hold_v) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hold_d;
      end else begin
        s_axis_tvalid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_axis_tdata  = $urandom;
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      acc = s_axis_tvalid & s_axis_tready;
      pop = m_axis_tvalid & m_axis_tready;
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("rnd spurious beat", 64'(m_axis_tdata), 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rnd beat col%0d row%0d", e[DWT+2], e[DWT+1]),
              64'({m_axis_tdata, eol, eof, sof}), 64'(e[DWT-1+3:0]));
        end
      end
      if (acc) begin
        exp_q.push_back({s_axis_tdata, mcol, mrow & mcol, (!mcol) & (!mrow)});
        if (mcol) begin
          if (mrow) mfc = mfc + 2'd1;
          mrow = ~mrow;
        end
        mcol = ~mcol;
        sent++;
      end
      hold_v = s_axis_tvalid & !acc;
      hold_d = s_axis_tdata;
      @(posedge clock);
      #1;
      cycles++;
    end
    chk("rnd completed in budget", 64'(cycles < 20000), 1);
    chk("rnd fcnt", 64'(o_frame_cnt), 64'(mfc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4s_frame_tagger.md
Name: axi4s_frame_tagger

Overview:
- Parametrised AXI4-Stream pixel pipeline stage for the image-verify datapath: one register slice with full throughput and a skid buffer.
- Tags every beat with end-of-line (eol), end-of-frame (eof) and start-of-frame (sof), derived from internal beat/line counters.
- Sits between the image source and the DUT/scoreboard, generalising the fixed 96-bit, externally-flagged stream to arbitrary pixel width, pixels-per-beat and frame geometry.

Parameters:
- PIX_W, 24, bits per pixel.
- PPC, 4, pixels per beat; data width DW = PIX_W*PPC (default 96).
- IMG_W, 640, pixels per line; must be a multiple of PPC. BPL = IMG_W/PPC beats per line.
- IMG_H, 480, lines per frame.
- FCNT_W, 16, frame counter width.

Ports:
- clock  in  1  sole clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DW  input pixels; pixel 0 in bits [PIX_W-1:0].
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DW  output pixels, unmodified.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- eol  out  1  qualifies the current m beat as the last beat of a line.
- eof  out  1  qualifies the current m beat as the last beat of a frame; implies eol.
- sof  out  1  qualifies the current m beat as the first beat of a frame.
- o_col  out  $clog2(BPL)  beat index of the next input beat.
- o_row  out  $clog2(IMG_H)  line index of the next input beat.
- o_frame_cnt  out  FCNT_W  number of completed frames accepted; wraps.

Behaviour:
- Reset (i_rstn=0, asynchronous): all outputs 0, including s_axis_tready. Counters and the skid buffer are cleared.
- s_axis_tready rises on the first rising edge after reset release.
- Reset mid-frame: in-flight beats are discarded; the next accepted beat is col=0, row=0 with sof=1.
- Accept = s_axis_tvalid & s_axis_tready. Counters advance only on accept; tags are computed at accept and travel with the data.
  - col wraps BPL-1 -> 0; row increments on that wrap.
  - row wraps IMG_H-1 -> 0; o_frame_cnt increments on that wrap.
  - Tag rules: eol = (col==BPL-1); eof = eol & (row==IMG_H-1); sof = (col==0 & row==0).
- Output stage is a main register plus one skid entry, each holding {data, eol, eof, sof}.
  - Latency: input accepted at edge N appears on m_axis at edge N (registered; visible the cycle after acceptance).
  - Sustained throughput is 1 beat/clock when m_axis_tready=1.
  - s_axis_tready is a register: 0 only when the skid entry is full. It never depends combinationally on m_axis_tready.
- Main/skid state machine:
  - EMPTY: accept -> FULL1.
  - FULL1: if accept and no output pop -> FULL2, beat stored in skid; s_axis_tready drops next cycle. If accept and pop -> FULL1. If pop only -> EMPTY.
  - FULL2: s_axis_tready=0; on pop, skid moves to main -> FULL1.
- AXI rules:
  - m_axis_tvalid, once high, stays high with tdata and tags stable until m_axis_tready.
  - A beat is never dropped or duplicated.
  - Simultaneous accept and pop in FULL1 keeps occupancy constant.
- Backpressure never changes counters; tags are immune to stalls.
- BPL=1: every beat has eol=1. IMG_H=1: every eol beat also has eof=1.

Decomposition:
- Package axi4s_img_pkg: the PIX_W/PPC/IMG_W/IMG_H defaults, the DW and BPL derived constants, and a packed struct beat_t = {tdata, eol, eof, sof}.
- One sub-module, axi4s_skid_slice: generic two-entry skid register over beat_t. The counters and tag generation stay in the top module.

Test Plan:
- Reset then continuous stream (IMG_W=8, PPC=4, IMG_H=2; m_ready=1): s_ready=1 one cycle after reset release. The 4 beats come out one per clock with eol pattern 0,1,0,1, eof only on beat 4, sof only on beat 1, and o_frame_cnt=1.
- Backpressure: m_ready=0 for 3 cycles mid-line while s_valid=1 -> s_ready=0 after 2 accepted beats. Data and tags stay stable; order is preserved with no loss once m_ready returns to 1.
- Simultaneous push/pop in FULL1 with alternating m_ready -> s_ready stays 1, output matches input sequence 0xA..A, 0xB..B.
- Reset asserted after beat 3 of frame -> all outputs 0 immediately. The first beat after reset has sof=1, eol=0, and o_frame_cnt=0.
- Counter wrap with FCNT_W=2 and 5 frames -> o_frame_cnt sequence 1,2,3,0,1.
- Random valid/ready at 50% over 1000 beats -> tdata sequence equals input and the tags match the reference col/row model.
